spram_mau: RTL and testbench
============================

Name: spram_mau

Overview:
- Memory access unit directly upstream of the 32K x 32-bit single-port SPRAM macro.
- Converts byte-addressed byte/half/word loads and stores from the eForth core into word accesses with byte-lane masks.
- Splits an access that crosses a word boundary into two back-to-back SPRAM accesses and merges the read data.
- Provides a 128 KB byte-addressable view of the 32-bit memory, with a req/ack handshake toward the core.

Parameters:
- AW, 17, byte-address width (128 KB).
- MW, 15, SPRAM word-address width; MW == AW-2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  1  access request, sampled only while rdy=1
- we  in  1  0 = load, 1 = store
- sz  in  2  access size: 0 byte, 1 half, 2 word; 3 is illegal and is treated as word
- addr  in  AW  byte address, any alignment
- wdat  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rdy  out  1  unit idle, can accept req
- ack  out  1  one-cycle completion pulse
- rdat  out  32  load data, zero-extended, right-justified; valid while ack=1, held until the next load ack
- m_we  out  1  to SPRAM we
- m_bmsk  out  4  to SPRAM byte mask
- m_a  out  MW  to SPRAM word address
- m_vi  out  32  to SPRAM write data
- m_vo  in  32  from SPRAM; valid the cycle after the address is presented

Behaviour:
- Lane mapping: big-endian. Byte offset k within a word maps to bits [31-8k:24-8k] and to m_bmsk[3-k]. The most-significant byte of a half or word sits at the lowest address.
- Definitions: o = addr[1:0]; n = 1, 2 or 4 bytes; split = (o+n > 4). wa = addr[AW-1:2]; wb = wa+1 modulo 2^MW, so word 0x7FFF wraps to word 0.
- Lane placement: place the n data bytes, left-justified, into a 64-bit window at byte offset o. The upper 32 bits go to word wa; the lower 32 bits go to word wb. Mask8 marks the occupied bytes; m_bmsk takes the upper or lower nibble accordingly.
- State machine (states in the package): IDLE, RD0, RD1, WR1. rdy = (state==IDLE).
- IDLE with req:
  - SPRAM outputs are driven combinationally from the inputs this cycle.
  - m_a = wa; m_bmsk = upper mask nibble; m_we = we; m_vi = upper write lanes.
  - Request fields (we, o, n, wb, lower lanes) are registered.
- Next state from IDLE:
  - Aligned store: stay in IDLE; ack=1 next cycle (latency 1).
  - Split store: go to WR1.
  - Any load: go to RD0.
- WR1: drive m_a=wb, m_we=1, lower mask and lower lanes. Then go to IDLE with ack=1 next cycle (latency 2).
- RD0: m_vo holds word wa.
  - Not split: extract the n bytes at offset o, zero-extend, register into rdat, go to IDLE, ack=1 next cycle (latency 2).
  - Split: capture bytes o..3 into a hold register, drive m_a=wb with m_we=0, go to RD1.
- RD1: merge the hold register (high bytes) with m_vo leading bytes (low bytes), register into rdat, go to IDLE, ack=1 next cycle (latency 3).
- Outputs outside active cycles:
  - In RD0 (non-split) and in IDLE without req: m_we=0, m_bmsk=0; m_a/m_vi are don't-care.
  - On loads m_bmsk is 4'hF; SPRAM masks are ignored on reads.
- Back-to-back: a req may be accepted in the same cycle ack is high, because state is already IDLE.
- A req raised while rdy=0 is ignored. The core must hold req until it is accepted.
- Reset: state=IDLE, ack=0, rdat=0, hold register=0, rdy=1, m_we=0, m_bmsk=0, m_a=0, m_vi=0.
  - rst asserted mid-split abandons the operation; the second write of a split store is not performed.
  - ack is not produced for an abandoned operation.
  - Memory contents are not restored.
- rdat changes only on a load completion; it is unchanged on store acks.

Decomposition:
- Package spram_mau_pkg:
  - enum size_t {SZ_B=0, SZ_H=1, SZ_W=2}
  - enum state_t {IDLE, RD0, RD1, WR1}
  - function size_bytes(size_t), returning 1/2/4.
- One combinational sub-module, mau_lane: takes (o, n, wdat) and produces mask8[7:0] and wide[63:0] lanes. It also provides read-side byte extraction from a 64-bit {hold, m_vo} window.
- The FSM and registers stay in spram_mau.

Test Plan:
- Aligned word store addr=0x00010, wdat=0xDEADBEEF -> m_a=4, m_bmsk=F, m_vi=DEADBEEF in the accept cycle, ack at +1; word load addr=0x10 -> ack at +2, rdat=0xDEADBEEF.
- Byte store addr=0x00013, wdat=0x5A -> m_bmsk=0001, m_vi[7:0]=5A; byte load 0x11 after the word above -> rdat=0x000000AD.
- Split half store addr=0x00023, wdat=0x1234 -> cycle0 m_a=8 mask 0001 vi[7:0]=12; cycle1 m_a=9 mask 1000 vi[31:24]=34; ack +2. Half load 0x23 -> rdat=0x00001234, ack +3.
- Wrap: word store addr=0x1FFFE, wdat=0xA1B2C3D4 -> accesses word 0x7FFF mask 0011, then word 0x0000 mask 1100. Load reads back 0xA1B2C3D4.
- Back-to-back: aligned store acked at T+1 with a new load req at T+1 -> accepted at T+1 (rdy=1), load ack at T+3; req during RD0 is ignored until rdy.
- Reset in WR1 of a split word store -> no second write (m_we=0 after reset), no ack, rdy=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/spram_mau_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spram_mau_pkg                                                |
// | Description : Shared types and helpers for the SPRAM memory access unit.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spram_mau_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR1  = 2'd3
  } state_t;

  function automatic logic [2:0] size_bytes(input size_t s);
    case (s)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spram_mau_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mau_lane                                                     |
// | Description : Big-endian byte-lane placement over a 64-bit two-word window |
// |               for stores, and byte extraction from the window for loads.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mau_lane (
  input  logic [1:0]  o_i,
  input  logic [2:0]  n_i,
  input  logic [31:0] wdat_i,
  input  logic [63:0] win_i,
  output logic [7:0]  mask8_o,
  output logic [63:0] wide_o,
  output logic [31:0] rdat_o
);

  logic [5:0]  w_osh;
  logic [5:0]  w_rsh;
  logic [3:0]  w_nmsk;
  logic [31:0] w_lj;
  logic [63:0] w_win_sh;

  always_comb begin
    w_osh = {1'b0, o_i, 3'b000};
    // Left-justify distance: (4-n) bytes; n is always 1, 2 or 4.
    w_rsh = {3'd4 - n_i, 3'b000};
    case (n_i)
      3'd1:    w_nmsk = 4'b1000;
      3'd2:    w_nmsk = 4'b1100;
      default: w_nmsk = 4'b1111;
    endcase
    w_lj     = wdat_i << w_rsh;
    wide_o   = {w_lj, 32'h0} >> w_osh;
    mask8_o  = {w_nmsk, 4'h0} >> o_i;
    w_win_sh = win_i << w_osh;
    rdat_o   = w_win_sh[63:32] >> w_rsh;
  end

endmodule
`default_nettype wire

// File: rtl/spram_mau.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spram_mau                                                    |
// | Description : Byte-addressed load/store front end for a 32-bit SPRAM,      |
// |               splitting word-crossing accesses into two word cycles.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spram_mau
  import spram_mau_pkg::*;
#(
  parameter int AW = 17,
  parameter int MW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdat,
  output logic          rdy,
  output logic          ack,
  output logic [31:0]   rdat,
  output logic          m_we,
  output logic [3:0]    m_bmsk,
  output logic [MW-1:0] m_a,
  output logic [31:0]   m_vi,
  input  logic [31:0]   m_vo
);

  state_t        state_q, state_d;
  logic [1:0]    o_q, o_d;
  logic [2:0]    n_q, n_d;
  logic [MW-1:0] wb_q, wb_d;
  logic [31:0]   vi_lo_q, vi_lo_d;
  logic [3:0]    msk_lo_q, msk_lo_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [31:0]   hold_q, hold_d;

  size_t         w_sz;
  logic [1:0]    w_o;
  logic [2:0]    w_n;
  logic [MW-1:0] w_wa;
  logic [MW-1:0] w_wb;
  logic          w_split_in;
  logic          w_split_q;
  logic [1:0]    w_lane_o;
  logic [2:0]    w_lane_n;
  logic [63:0]   w_win;
  logic [7:0]    w_mask8;
  logic [63:0]   w_wide;
  logic [31:0]   w_rd;

  always_comb begin
    case (sz)
      2'd0:    w_sz = SZ_B;
      2'd1:    w_sz = SZ_H;
      default: w_sz = SZ_W;
    endcase
    w_o        = addr[1:0];
    w_n        = size_bytes(w_sz);
    w_wa       = addr[AW-1:2];
    w_wb       = w_wa + MW'(1);
    w_split_in = ({2'b00, w_o} + {1'b0, w_n}) > 4'd4;
    w_split_q  = ({2'b00, o_q} + {1'b0, n_q}) > 4'd4;
    w_lane_o   = (state_q == IDLE) ? w_o : o_q;
    w_lane_n   = (state_q == IDLE) ? w_n : n_q;
    // RD1 window: first word (held) on top, second word from the SPRAM below.
    w_win      = (state_q == RD1) ? {hold_q, m_vo} : {m_vo, 32'h0};
  end

  mau_lane u_lane (
    .o_i     (w_lane_o),
    .n_i     (w_lane_n),
    .wdat_i  (wdat),
    .win_i   (w_win),
    .mask8_o (w_mask8),
    .wide_o  (w_wide),
    .rdat_o  (w_rd)
  );

  always_comb begin
    state_d  = state_q;
    o_d      = o_q;
    n_d      = n_q;
    wb_d     = wb_q;
    vi_lo_d  = vi_lo_q;
    msk_lo_d = msk_lo_q;
    ack_d    = 1'b0;
    rdat_d   = rdat_q;
    hold_d   = hold_q;
    m_we     = 1'b0;
    m_bmsk   = 4'h0;
    m_a      = '0;
    m_vi     = 32'h0;
    case (state_q)
      IDLE: begin
        if (req) begin
          m_a      = w_wa;
          m_we     = we;
          m_bmsk   = we ? w_mask8[7:4] : 4'hF;
          m_vi     = w_wide[63:32];
          o_d      = w_o;
          n_d      = w_n;
          wb_d     = w_wb;
          vi_lo_d  = w_wide[31:0];
          msk_lo_d = w_mask8[3:0];
          if (!we)             state_d = RD0;
          else if (w_split_in) state_d = WR1;
          else                 ack_d   = 1'b1;
        end
      end
      WR1: begin
        m_a     = wb_q;
        m_we    = 1'b1;
        m_bmsk  = msk_lo_q;
        m_vi    = vi_lo_q;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      RD0: begin
        if (w_split_q) begin
          hold_d  = m_vo;
          m_a     = wb_q;
          m_bmsk  = 4'hF;
          state_d = RD1;
        end else begin
          rdat_d  = w_rd;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD1: begin
        rdat_d  = w_rd;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Silence the SPRAM while in reset so an interrupted split store never commits its second half.
    if (rst) begin
      m_we   = 1'b0;
      m_bmsk = 4'h0;
      m_a    = '0;
      m_vi   = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      o_q      <= 2'd0;
      n_q      <= 3'd0;
      wb_q     <= '0;
      vi_lo_q  <= 32'h0;
      msk_lo_q <= 4'h0;
      ack_q    <= 1'b0;
      rdat_q   <= 32'h0;
      hold_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      o_q      <= o_d;
      n_q      <= n_d;
      wb_q     <= wb_d;
      vi_lo_q  <= vi_lo_d;
      msk_lo_q <= msk_lo_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      hold_q   <= hold_d;
    end
  end

  assign rdy  = (state_q == IDLE);
  assign ack  = ack_q;
  assign rdat = rdat_q;

endmodule
`default_nettype wire

// File: tb/tb_spram_mau.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spram_mau                                                 |
// | Description : Directed self-checking bench with SPRAM model, byte-level    |
// |               reference memory and an expected-result queue.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spram_mau;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  sz;
  logic [16:0] addr;
  logic [31:0] wdat;
  logic        rdy;
  logic        ack;
  logic [31:0] rdat;
  logic        m_we;
  logic [3:0]  m_bmsk;
  logic [14:0] m_a;
  logic [31:0] m_vi;
  logic [31:0] m_vo;

  typedef struct {
    logic [31:0] rdat;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  refm [0:131071];
  logic [31:0] mem  [0:32767];
  logic [31:0] last_rd;
  logic [51:0] snap0, snap1;

  always #5 clk = ~clk;

  spram_mau #(.AW(17), .MW(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .sz     (sz),
    .addr   (addr),
    .wdat   (wdat),
    .rdy    (rdy),
    .ack    (ack),
    .rdat   (rdat),
    .m_we   (m_we),
    .m_bmsk (m_bmsk),
    .m_a    (m_a),
    .m_vi   (m_vi),
    .m_vo   (m_vo)
  );

  // SPRAM model: masked big-endian write, registered read.
  always @(posedge clk) begin
    if (m_we)
      for (int k = 0; k < 4; k++)
        if (m_bmsk[3-k]) mem[m_a][31-8*k -: 8] <= m_vi[31-8*k -: 8];
    m_vo <= mem[m_a];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input logic [51:0] s, input logic ewe,
                          input logic [3:0] ebm, input logic [14:0] ea,
                          input logic [31:0] evi, input logic [31:0] vmask);
    chk({tag, "_we"},   s[51],    ewe);
    chk({tag, "_bmsk"}, s[50:47], ebm);
    chk({tag, "_a"},    s[46:32], ea);
    chk({tag, "_vi"},   s[31:0] & vmask, evi & vmask);
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic [16:0] a,
                       input logic [31:0] d, input int lat, input bit model);
    int          n;
    logic [31:0] v;
    n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    req  = 1'b1;
    we   = w;
    sz   = s;
    addr = a;
    wdat = d;
    if (!model) return;
    if (w) begin
      for (int i = 0; i < n; i++) refm[17'(a + i)] = 8'(d >> (8 * (n - 1 - i)));
      sbq.push_back('{last_rd, lat});
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, refm[17'(a + i)]};
      last_rd = v;
      sbq.push_back('{v, lat});
    end
  endtask

  task automatic pop_chk(input int lat);
    exp_t e;
    tests++;
    assert (sbq.size() > 0) else begin
      fails++;
      $error("FAIL sb_empty: observed ack with no pending request, expected a pending entry");
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rdat", rdat, e.rdat);
      if (lat >= 0) chk("latency", lat, e.lat);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] s, input logic [16:0] a,
                        input logic [31:0] d, input int lat);
    int n_cyc;
    chk("rdy_before_req", rdy, 1'b1);
    drive(w, s, a, d, lat, 1'b1);
    #1 snap0 = {m_we, m_bmsk, m_a, m_vi};
    @(posedge clk); #1 req = 1'b0;
    #1 snap1 = {m_we, m_bmsk, m_a, m_vi};
    n_cyc = 1;
    while (!ack && n_cyc < 8) begin
      @(posedge clk); #2;
      n_cyc++;
    end
    chk("ack_seen", ack, 1'b1);
    pop_chk(n_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    for (int i = 0; i < 131072; i++) refm[i] = 8'h0;
    last_rd = 32'h0;
    rst = 1'b1; req = 1'b0; we = 1'b0; sz = 2'd0; addr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdat", rdat, 32'h0);
    chk_snap("rst_m", {m_we, m_bmsk, m_a, m_vi}, 1'b0, 4'h0, 15'h0, 32'h0, 32'hFFFF_FFFF);

    // Aligned word store, then immediate back-to-back word load.
    access(1'b1, 2'd2, 17'h00010, 32'hDEAD_BEEF, 1);
    chk_snap("st_w", snap0, 1'b1, 4'hF, 15'h0004, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    chk("st_w_next_we", snap1[51], 1'b0);
    chk("b2b_ack_high", ack, 1'b1);
    access(1'b0, 2'd2, 17'h00010, 32'h0, 2);

    // Byte store and byte loads.
    access(1'b1, 2'd0, 17'h00013, 32'h0000_005A, 1);
    chk_snap("st_b", snap0, 1'b1, 4'b0001, 15'h0004, 32'h0000_005A, 32'h0000_00FF);
    access(1'b0, 2'd0, 17'h00011, 32'h0, 2);
    access(1'b0, 2'd2, 17'h00010, 32'h0, 2);

    // Word-crossing half store and load.
    access(1'b1, 2'd1, 17'h00023, 32'h0000_1234, 2);
    chk_snap("st_hs0", snap0, 1'b1, 4'b0001, 15'h0008, 32'h0000_0012, 32'h0000_00FF);
    chk_snap("st_hs1", snap1, 1'b1, 4'b1000, 15'h0009, 32'h3400_0000, 32'hFF00_0000);
    access(1'b0, 2'd1, 17'h00023, 32'h0, 3);
    chk_snap("ld_hs0", snap0, 1'b0, 4'hF, 15'h0008, 32'h0, 32'h0);
    chk_snap("ld_hs1", snap1, 1'b0, 4'hF, 15'h0009, 32'h0, 32'h0);
    access(1'b0, 2'd1, 17'h00012, 32'h0, 2);

    // Top-of-memory wrap to word 0.
    access(1'b1, 2'd2, 17'h1FFFE, 32'hA1B2_C3D4, 2);
    chk_snap("wrap0", snap0, 1'b1, 4'b0011, 15'h7FFF, 32'h0000_A1B2, 32'h0000_FFFF);
    chk_snap("wrap1", snap1, 1'b1, 4'b1100, 15'h0000, 32'hC3D4_0000, 32'hFFFF_0000);
    access(1'b0, 2'd2, 17'h1FFFE, 32'h0, 3);

    // Illegal size 3 behaves as word.
    access(1'b0, 2'd3, 17'h00010, 32'h0, 2);

    // Request held through RD0 is not accepted until rdy.
    chk("ign_rdy_start", rdy, 1'b1);
    drive(1'b0, 2'd2, 17'h00010, 32'h0, 2, 1'b1);
    @(posedge clk); #1 drive(1'b1, 2'd2, 17'h00014, 32'hCAFE_F00D, 1, 1'b1);
    #1;
    chk("ign_rdy_busy", rdy, 1'b0);
    chk("ign_no_write", m_we, 1'b0);
    @(posedge clk); #2;
    chk("ign_ld_ack", ack, 1'b1);
    pop_chk(-1);
    chk("ign_rdy_again", rdy, 1'b1);
    chk("ign_st_we", m_we, 1'b1);
    chk("ign_st_a", m_a, 15'h0005);
    @(posedge clk); #1 req = 1'b0;
    #1;
    chk("ign_st_ack", ack, 1'b1);
    pop_chk(-1);
    access(1'b0, 2'd2, 17'h00014, 32'h0, 2);

    // Reset during WR1 of a split word store abandons the second write.
    access(1'b1, 2'd2, 17'h00034, 32'h5566_7788, 1);
    drive(1'b1, 2'd2, 17'h00031, 32'h1122_3344, 0, 1'b0);
    refm[17'h31] = 8'h11; refm[17'h32] = 8'h22; refm[17'h33] = 8'h33;
    #1 snap0 = {m_we, m_bmsk, m_a, m_vi};
    chk_snap("rst_sp0", snap0, 1'b1, 4'b0111, 15'h000C, 32'h0011_2233, 32'h00FF_FFFF);
    @(posedge clk); #1 req = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; last_rd = 32'h0;
    #1;
    chk("rst_mid_rdy", rdy, 1'b1);
    chk("rst_mid_ack", ack, 1'b0);
    chk("rst_mid_we", m_we, 1'b0);
    chk("rst_mid_rdat", rdat, 32'h0);
    repeat (2) begin
      @(posedge clk); #2;
      chk("rst_no_ack", ack, 1'b0);
    end
    access(1'b0, 2'd2, 17'h00034, 32'h0, 2);
    access(1'b0, 2'd2, 17'h00030, 32'h0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
